// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed hex 7-segment scan driver
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blz;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                all_zero;
  logic [DIGITS-1:0]   cur_sel;
  logic [6:0]          seg_lit_n;
  logic [6:0]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   dig_next;
  logic                tick;
  logic                wrap;

  // Active-low pattern, bit order g..a
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg_n = 7'h40;
      4'h1: hex_to_seg_n = 7'h79;
      4'h2: hex_to_seg_n = 7'h24;
      4'h3: hex_to_seg_n = 7'h30;
      4'h4: hex_to_seg_n = 7'h19;
      4'h5: hex_to_seg_n = 7'h12;
      4'h6: hex_to_seg_n = 7'h02;
      4'h7: hex_to_seg_n = 7'h78;
      4'h8: hex_to_seg_n = 7'h00;
      4'h9: hex_to_seg_n = 7'h10;
      4'hA: hex_to_seg_n = 7'h08;
      4'hB: hex_to_seg_n = 7'h03;
      4'hC: hex_to_seg_n = 7'h27;
      4'hD: hex_to_seg_n = 7'h21;
      4'hE: hex_to_seg_n = 7'h06;
      default: hex_to_seg_n = 7'h0E;
    endcase
  endfunction

  // Walk from the top digit down so all_zero covers nibbles i..DIGITS-1
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (sh_value[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        cur_nib    = sh_value[4*i +: 4];
        cur_dp     = sh_dp[i];
        cur_sel[i] = 1'b1;
        cur_blank  = sh_blz && (i != 0) && all_zero;
      end
    end
  end

  assign seg_lit_n = cur_blank ? 7'h7F : hex_to_seg_n(cur_nib);
  assign seg_next  = SEG_ACTIVE_LOW ? seg_lit_n : ~seg_lit_n;
  assign dp_next   = SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
  assign dig_next  = DIG_ACTIVE_LOW ? ~cur_sel : cur_sel;
  assign tick      = enable && (cnt == CNT_LAST);
  assign wrap      = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blz   <= 1'b0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_blz   <= blank_lz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
        idx <= wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end else if (enable) begin
      seg_out    <= seg_next;
      dp_out     <= dp_next;
      dig_sel    <= dig_next;
      frame_done <= wrap;
    end else begin
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;
  logic [3:0]  dig_a, dig_b;

  int passed = 0;
  int total  = 0;

  seg7_scan_driver #(.DIGITS(4), .DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg_out(seg_a), .dp_out(dp_a),
    .dig_sel(dig_a), .frame_done(fd_a));

  seg7_scan_driver #(.DIGITS(4), .DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg_out(seg_b), .dp_out(dp_b),
    .dig_sel(dig_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: digit shown and frame position follow from the count of enabled cycles
  logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
  int          e_cnt = 0;
  int          m_d;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_blz = 1'b0;
  logic [6:0]  x_seg = 7'h7F;
  logic        x_dp = 1'b1;
  logic [3:0]  x_dig = 4'hF;
  logic        x_fd = 1'b0;

  task automatic model_reset();
    e_cnt = 0; m_val = 16'h0; m_dp = 4'h0; m_blz = 1'b0;
    x_seg = 7'h7F; x_dp = 1'b1; x_dig = 4'hF; x_fd = 1'b0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (enable) begin
        m_d   = (e_cnt / 4) % 4;
        x_seg = (m_blz && m_d != 0 && (m_val >> (4 * m_d)) == 16'h0) ? 7'h7F
                : seg_tbl[(m_val >> (4 * m_d)) & 16'hF];
        x_dp  = ~m_dp[m_d];
        x_dig = ~(4'b0001 << m_d);
        x_fd  = (e_cnt % 16) == 15;
        e_cnt++;
      end else begin
        x_seg = 7'h7F; x_dp = 1'b1; x_dig = 4'hF; x_fd = 1'b0;
      end
      if (load) begin
        m_val = value; m_dp = dp_in; m_blz = blank_lz;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("cycle_a", {seg_a, dp_a, dig_a, fd_a}, {x_seg, x_dp, x_dig, x_fd});
    chk("cycle_b", {seg_b, dp_b, dig_b, fd_b}, {~x_seg, ~x_dp, ~x_dig, x_fd});
  end

  task automatic load_val(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    @(negedge clk);
    value = v; dp_in = dp; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_digit(input int d);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #2;
      if (dig_a == ~(4'b0001 << d)) found = 1'b1;
    end
    chk("wait_digit", found, 1'b1);
  endtask

  logic [15:0] hex_vals [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
  logic [6:0]  hex_lits [16] = '{7'h27, 7'h21, 7'h06, 7'h0E, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h19, 7'h12, 7'h02, 7'h78, 7'h40, 7'h79, 7'h24, 7'h30};
  logic [6:0]  lz_lits [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
  logic [6:0]  abs_lits [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  initial begin
    int pulses;
    rst_n = 1'b0; value = 16'hBEEF; dp_in = 4'hF; load = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_seg", seg_a, 7'h7F);
    chk("rst_dp", dp_a, 1'b1);
    chk("rst_dig", dig_a, 4'hF);
    chk("rst_fd", fd_a, 1'b0);
    chk("rst_dig_b", dig_b, 4'h0);

    @(negedge clk);
    rst_n = 1'b1; load = 1'b0; enable = 1'b0;
    load_val(16'h1234, 4'h0, 1'b0);
    enable = 1'b1;
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      chk("abs_seg", seg_a, abs_lits[d]);
    end
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #2;
      if (fd_a) pulses++;
    end
    chk("frame_pulses", pulses, 2);

    for (int v = 0; v < 4; v++) begin
      load_val(hex_vals[v], 4'h0, 1'b0);
      for (int d = 0; d < 4; d++) begin
        wait_digit(d);
        chk("hex_seg", seg_a, hex_lits[4*v + d]);
      end
    end

    load_val(16'h0050, 4'h0, 1'b1);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      chk("lz_seg", seg_a, lz_lits[d]);
    end
    load_val(16'h0000, 4'h0, 1'b1);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      chk("lz0_seg", seg_a, (d == 0) ? 7'h40 : 7'h7F);
    end
    load_val(16'h0000, 4'h0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      chk("nolz_seg", seg_a, 7'h40);
    end

    load_val(16'h1234, 4'b0100, 1'b0);
    wait_digit(2);
    chk("dp_on", dp_a, 1'b0);
    chk("dp_on_b", dp_b, 1'b1);
    chk("dig_b", dig_b, 4'b0100);
    chk("seg_b", seg_b, 7'h5B);
    wait_digit(3);
    chk("dp_off", dp_a, 1'b1);

    wait_digit(1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #2;
    chk("dis_dig", dig_a, 4'hF);
    chk("dis_seg", seg_a, 7'h7F);
    repeat (10) @(negedge clk);
    enable = 1'b1;
    @(posedge clk); #2;
    chk("resume_dig", dig_a, 4'b1101);

    wait_digit(2);
    load_val(16'hAAAA, 4'h0, 1'b0);
    @(posedge clk); #2;
    chk("midload_seg", seg_a, 7'h08);
    chk("midload_dig", dig_a, 4'b1011);

    wait_digit(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", seg_a, 7'h7F);
    chk("arst_dig", dig_a, 4'hF);
    chk("arst_dp", dp_a, 1'b1);
    chk("arst_seg_b", seg_b, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("restart_dig", dig_a, 4'b1110);
    chk("restart_seg", seg_a, 7'h40);
    repeat (20) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
